// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: display-clock read engine for the dual-port framebuffer.
// Generates video timing, issues pixel-replicated reads to the RAM read port
// and realigns the returned data with de/hsync/vsync/frame_start.
// The RAM output register is the second pipeline stage for data, so pixel is
// a gated view of dout and lines up with the stage-2 timing registers.
// Optional feature: define FB_SCANOUT_TESTPATTERN_EN to add the test_mode
// input and the XOR test pattern generator.
`timescale 1ns/1ps
module framebuffer_scanout #(
   parameter int FRAME_WIDTH    = 640,
   parameter int FRAME_HEIGHT   = 480,
   parameter int H_FP           = 16,
   parameter int H_SYNC         = 96,
   parameter int H_BP           = 48,
   parameter int V_FP           = 10,
   parameter int V_SYNC         = 2,
   parameter int V_BP           = 33,
   parameter int SCALING_FACTOR = 1,
   parameter int ADDR_WIDTH     = 19,
   parameter int DATA_WIDTH     = 8,
   parameter int SYNC_POL       = 0
) (
   input  logic                  clk_rd,
   input  logic                  rst_n,
   input  logic                  enable,
`ifdef FB_SCANOUT_TESTPATTERN_EN
   input  logic                  test_mode,
`endif
   output logic                  en_rd,
   output logic [ADDR_WIDTH-1:0] addr_rd,
   input  logic [DATA_WIDTH-1:0] dout,
   output logic [DATA_WIDTH-1:0] pixel,
   output logic                  de,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  frame_start
);

   localparam int   H_TOTAL    = FRAME_WIDTH + H_FP + H_SYNC + H_BP;
   localparam int   V_TOTAL    = FRAME_HEIGHT + V_FP + V_SYNC + V_BP;
   localparam int   HW         = $clog2(H_TOTAL + 1);
   localparam int   VW         = $clog2(V_TOTAL + 1);
   localparam int   SW         = (SCALING_FACTOR > 1) ? $clog2(SCALING_FACTOR) : 1;
   localparam int   LINE_WORDS = FRAME_WIDTH / SCALING_FACTOR;
   localparam logic SYNC_ON    = (SYNC_POL != 0) ? 1'b1 : 1'b0;

   // stage 0: timing counters and address state
   logic [HW-1:0]         h_r;
   logic [VW-1:0]         v_r;
   logic [SW-1:0]         sub_x_r;
   logic [SW-1:0]         sub_y_r;
   logic [ADDR_WIDTH-1:0] col_r;
   logic [ADDR_WIDTH-1:0] line_base_r;

   // stage 0 decode
   logic                  active_s;
   logic                  hs_act_s;
   logic                  vs_act_s;
   logic                  origin_s;
   logic                  h_last_s;
   logic                  v_last_s;
   logic                  sub_x_last_s;
   logic                  sub_y_last_s;
   logic                  rd_s;
   logic [ADDR_WIDTH-1:0] addr_s;

   // stage 1 timing flags (en_rd/addr_rd are the stage-1 read outputs)
   logic act1_r;
   logic hs1_r;
   logic vs1_r;
   logic fs1_r;

`ifdef FB_SCANOUT_TESTPATTERN_EN
   logic [2:0] tp1_r;
   logic [2:0] tp2_r;
`endif

   // Decode the stage-0 counter state into windows, wrap points and the read address
   always_comb begin
      active_s     = (h_r < HW'(FRAME_WIDTH)) && (v_r < VW'(FRAME_HEIGHT));
      hs_act_s     = (h_r >= HW'(FRAME_WIDTH + H_FP)) &&
                     (h_r <  HW'(FRAME_WIDTH + H_FP + H_SYNC));
      vs_act_s     = (v_r >= VW'(FRAME_HEIGHT + V_FP)) &&
                     (v_r <  VW'(FRAME_HEIGHT + V_FP + V_SYNC));
      origin_s     = (h_r == {HW{1'b0}}) && (v_r == {VW{1'b0}});
      h_last_s     = (h_r == HW'(H_TOTAL - 1));
      v_last_s     = (v_r == VW'(V_TOTAL - 1));
      sub_x_last_s = (sub_x_r == SW'(SCALING_FACTOR - 1));
      sub_y_last_s = (sub_y_r == SW'(SCALING_FACTOR - 1));
      addr_s       = line_base_r + col_r;
`ifdef FB_SCANOUT_TESTPATTERN_EN
      rd_s         = active_s & ~test_mode;
`else
      rd_s         = active_s;
`endif
   end

   // Stage 0: h/v counters plus incremental column/line-base address tracking
   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         h_r         <= {HW{1'b0}};
         v_r         <= {VW{1'b0}};
         sub_x_r     <= {SW{1'b0}};
         sub_y_r     <= {SW{1'b0}};
         col_r       <= {ADDR_WIDTH{1'b0}};
         line_base_r <= {ADDR_WIDTH{1'b0}};
      end else if (!enable) begin
         h_r         <= {HW{1'b0}};
         v_r         <= {VW{1'b0}};
         sub_x_r     <= {SW{1'b0}};
         sub_y_r     <= {SW{1'b0}};
         col_r       <= {ADDR_WIDTH{1'b0}};
         line_base_r <= {ADDR_WIDTH{1'b0}};
      end else if (h_last_s) begin
         h_r     <= {HW{1'b0}};
         sub_x_r <= {SW{1'b0}};
         col_r   <= {ADDR_WIDTH{1'b0}};
         if (v_last_s) begin
            v_r         <= {VW{1'b0}};
            sub_y_r     <= {SW{1'b0}};
            line_base_r <= {ADDR_WIDTH{1'b0}};
         end else begin
            v_r <= v_r + VW'(1);
            // only active lines advance the vertical replication state
            if (v_r < VW'(FRAME_HEIGHT)) begin
               if (sub_y_last_s) begin
                  sub_y_r     <= {SW{1'b0}};
                  line_base_r <= line_base_r + ADDR_WIDTH'(LINE_WORDS);
               end else begin
                  sub_y_r <= sub_y_r + SW'(1);
               end
            end else begin
               sub_y_r <= sub_y_r;
            end
         end
      end else begin
         h_r <= h_r + HW'(1);
         if (active_s) begin
            if (sub_x_last_s) begin
               sub_x_r <= {SW{1'b0}};
               col_r   <= col_r + ADDR_WIDTH'(1);
            end else begin
               sub_x_r <= sub_x_r + SW'(1);
            end
         end else begin
            sub_x_r <= sub_x_r;
         end
      end
   end

   // Stages 1 and 2: read request, then timing flags aligned with RAM data
   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         en_rd       <= 1'b0;
         addr_rd     <= {ADDR_WIDTH{1'b0}};
         act1_r      <= 1'b0;
         hs1_r       <= 1'b0;
         vs1_r       <= 1'b0;
         fs1_r       <= 1'b0;
         de          <= 1'b0;
         hsync       <= ~SYNC_ON;
         vsync       <= ~SYNC_ON;
         frame_start <= 1'b0;
      end else begin
         if (enable) begin
            en_rd  <= rd_s;
            // address holds between reads so the RAM port stays quiet
            if (rd_s) begin
               addr_rd <= addr_s;
            end else begin
               addr_rd <= addr_rd;
            end
            act1_r <= active_s;
            hs1_r  <= hs_act_s;
            vs1_r  <= vs_act_s;
            fs1_r  <= origin_s;
         end else begin
            en_rd   <= 1'b0;
            addr_rd <= {ADDR_WIDTH{1'b0}};
            act1_r  <= 1'b0;
            hs1_r   <= 1'b0;
            vs1_r   <= 1'b0;
            fs1_r   <= 1'b0;
         end
         de          <= act1_r;
         hsync       <= hs1_r ? SYNC_ON : ~SYNC_ON;
         vsync       <= vs1_r ? SYNC_ON : ~SYNC_ON;
         frame_start <= fs1_r;
      end
   end

`ifdef FB_SCANOUT_TESTPATTERN_EN
   // Carry the XOR test pattern alongside the timing flags
   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         tp1_r <= 3'b000;
         tp2_r <= 3'b000;
      end else begin
         if (enable) begin
            tp1_r <= h_r[2:0] ^ v_r[2:0];
         end else begin
            tp1_r <= 3'b000;
         end
         tp2_r <= tp1_r;
      end
   end
`endif

   // Pixel output: RAM data (or test pattern) gated by the stage-2 active flag
   always_comb begin
      pixel = {DATA_WIDTH{1'b0}};
      if (de) begin
`ifdef FB_SCANOUT_TESTPATTERN_EN
         if (test_mode) begin
            pixel = DATA_WIDTH'(tp2_r);
         end else begin
            pixel = dout;
         end
`else
         pixel = dout;
`endif
      end else begin
         pixel = {DATA_WIDTH{1'b0}};
      end
   end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout: directed bench for framebuffer_scanout.
// Small 8x4 frame (14 clocks/line, 7 lines/frame); instance a uses S=1,
// instance b uses S=2. Each RAM model returns the address of the previous read.
`timescale 1ns/1ps
module tb_framebuffer_scanout;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en_a = 1'b1;
   logic        en_b = 1'b0;
`ifdef FB_SCANOUT_TESTPATTERN_EN
   logic        tm_a = 1'b0;
   logic        tm_b = 1'b0;
`endif

   logic        en_rd_a, en_rd_b;
   logic [18:0] addr_rd_a, addr_rd_b;
   logic [7:0]  dout_a = 8'h00;
   logic [7:0]  dout_b = 8'h00;
   logic [7:0]  pixel_a, pixel_b;
   logic        de_a, de_b, hsync_a, hsync_b, vsync_a, vsync_b, fs_a, fs_b;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   framebuffer_scanout #(
      .FRAME_WIDTH(8), .FRAME_HEIGHT(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_FP(1), .V_SYNC(1), .V_BP(1), .SCALING_FACTOR(1),
      .ADDR_WIDTH(19), .DATA_WIDTH(8), .SYNC_POL(0)
   ) dut_a (
      .clk_rd(clk), .rst_n(rst_n), .enable(en_a),
`ifdef FB_SCANOUT_TESTPATTERN_EN
      .test_mode(tm_a),
`endif
      .en_rd(en_rd_a), .addr_rd(addr_rd_a), .dout(dout_a), .pixel(pixel_a),
      .de(de_a), .hsync(hsync_a), .vsync(vsync_a), .frame_start(fs_a)
   );

   framebuffer_scanout #(
      .FRAME_WIDTH(8), .FRAME_HEIGHT(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_FP(1), .V_SYNC(1), .V_BP(1), .SCALING_FACTOR(2),
      .ADDR_WIDTH(19), .DATA_WIDTH(8), .SYNC_POL(0)
   ) dut_b (
      .clk_rd(clk), .rst_n(rst_n), .enable(en_b),
`ifdef FB_SCANOUT_TESTPATTERN_EN
      .test_mode(tm_b),
`endif
      .en_rd(en_rd_b), .addr_rd(addr_rd_b), .dout(dout_b), .pixel(pixel_b),
      .de(de_b), .hsync(hsync_b), .vsync(vsync_b), .frame_start(fs_b)
   );

   // Synchronous-read RAM models: data is the address read one cycle earlier
   always @(posedge clk) begin
      if (en_rd_a) dout_a <= addr_rd_a[7:0];
      if (en_rd_b) dout_b <= addr_rd_b[7:0];
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset_a(input string tag);
      check_vec({tag, "_en_rd"}, 32'(en_rd_a), 32'd0);
      check_vec({tag, "_addr"},  32'(addr_rd_a), 32'd0);
      check_vec({tag, "_pixel"}, 32'(pixel_a), 32'd0);
      check_vec({tag, "_de"},    32'(de_a), 32'd0);
      check_vec({tag, "_fs"},    32'(fs_a), 32'd0);
      check_vec({tag, "_hsync"}, 32'(hsync_a), 32'd1);
      check_vec({tag, "_vsync"}, 32'(vsync_a), 32'd1);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_a("rst");
      check_vec("rst_b_en_rd", 32'(en_rd_b), 32'd0);
      check_vec("rst_b_hsync", 32'(hsync_b), 32'd1);

      // ---- S=1 frame after reset release ----
      rst_n = 1'b1;
      @(negedge clk);
      check_vec("clk1_fs", 32'(fs_a), 32'd0);
      check_vec("clk1_en_rd", 32'(en_rd_a), 32'd1);
      check_vec("clk1_addr", 32'(addr_rd_a), 32'd0);
      @(negedge clk);
      for (int i = 0; i <= 98; i++) begin
         int h;
         int v;
         logic act;
         h   = i % 14;
         v   = (i / 14) % 7;
         act = (h < 8) && (v < 4);
         check_vec($sformatf("de_%0d", i),    32'(de_a), 32'(act));
         check_vec($sformatf("pix_%0d", i),   32'(pixel_a), act ? 32'(v * 8 + h) : 32'd0);
         check_vec($sformatf("hs_%0d", i),    32'(hsync_a), (h == 10 || h == 11) ? 32'd0 : 32'd1);
         check_vec($sformatf("vs_%0d", i),    32'(vsync_a), (v == 5) ? 32'd0 : 32'd1);
         check_vec($sformatf("fs_%0d", i),    32'(fs_a), (h == 0 && v == 0) ? 32'd1 : 32'd0);
         @(negedge clk);
      end

      // ---- enable dropped with stage 0 at v=2, h=3 ----
      repeat (28) @(negedge clk);
      check_vec("pre_drop_de", 32'(de_a), 32'd1);
      check_vec("pre_drop_pix", 32'(pixel_a), 32'd17);
      en_a = 1'b0;
      @(negedge clk);
      check_vec("drop1_en_rd", 32'(en_rd_a), 32'd0);
      @(negedge clk);
      check_reset_a("drop2");
      repeat (3) @(negedge clk);
      check_vec("drop_hold_de", 32'(de_a), 32'd0);
      check_vec("drop_hold_en_rd", 32'(en_rd_a), 32'd0);

      // ---- re-enable ----
      en_a = 1'b1;
      @(negedge clk);
      check_vec("reen1_fs", 32'(fs_a), 32'd0);
      check_vec("reen1_en_rd", 32'(en_rd_a), 32'd1);
      check_vec("reen1_addr", 32'(addr_rd_a), 32'd0);
      @(negedge clk);
      check_vec("reen2_fs", 32'(fs_a), 32'd1);
      check_vec("reen2_de", 32'(de_a), 32'd1);
      check_vec("reen2_pix", 32'(pixel_a), 32'd0);
      repeat (5) @(negedge clk);
      check_vec("midline_pix", 32'(pixel_a), 32'd5);
      check_vec("midline_addr", 32'(addr_rd_a), 32'd6);

      // ---- asynchronous reset mid-line, checked between clock edges ----
      #2 rst_n = 1'b0;
      #1 check_reset_a("async");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_vec("rerst1_fs", 32'(fs_a), 32'd0);
      @(negedge clk);
      check_vec("rerst2_fs", 32'(fs_a), 32'd1);
      check_vec("rerst2_de", 32'(de_a), 32'd1);

      // ---- S=2 address replication ----
      en_b = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 98; i++) begin
         int h;
         int v;
         int hp;
         int vp;
         h  = i % 14;
         v  = i / 14;
         hp = (i + 97) % 14;
         vp = ((i + 97) / 14) % 7;
         if (h < 8 && v < 4) begin
            check_vec($sformatf("b_en_%0d", i), 32'(en_rd_b), 32'd1);
            check_vec($sformatf("b_addr_%0d", i), 32'(addr_rd_b), 32'((v / 2) * 4 + h / 2));
         end else begin
            check_vec($sformatf("b_en_%0d", i), 32'(en_rd_b), 32'd0);
         end
         if (i >= 1 && hp < 8 && vp < 4) begin
            check_vec($sformatf("b_pix_%0d", i), 32'(pixel_b), 32'((vp / 2) * 4 + hp / 2));
         end else begin
            check_vec($sformatf("b_de_%0d", i), 32'(de_b), 32'd0);
         end
         @(negedge clk);
      end
      check_vec("b_wrap_en", 32'(en_rd_b), 32'd1);
      check_vec("b_wrap_addr", 32'(addr_rd_b), 32'd0);

`ifdef FB_SCANOUT_TESTPATTERN_EN
      // ---- test pattern mode ----
      tm_a  = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 98; i++) begin
         int h;
         int v;
         logic act;
         h   = i % 14;
         v   = i / 14;
         act = (h < 8) && (v < 4);
         check_vec($sformatf("tm_en_%0d", i), 32'(en_rd_a), 32'd0);
         check_vec($sformatf("tm_hs_%0d", i), 32'(hsync_a), (h == 10 || h == 11) ? 32'd0 : 32'd1);
         check_vec($sformatf("tm_vs_%0d", i), 32'(vsync_a), (v == 5) ? 32'd0 : 32'd1);
         check_vec($sformatf("tm_pix_%0d", i), 32'(pixel_a), act ? 32'((h % 8) ^ (v % 8)) : 32'd0);
         if (i == 47) check_vec("tm_pix_5_3", 32'(pixel_a), 32'd6);
         @(negedge clk);
      end
      tm_a = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
